// File: rtl/demux32_collector.sv
// ---------------------------------------------------------------------------
// demux32_collector
//
// Purpose:
//   Rebuilds a 32-bit parallel word from a stream of single bits, each of
//   which arrives with the 5-bit index of the position it belongs to. This is
//   the inverse of a 32:1 bit-select mux. Once every position of the word has
//   been written, the word is presented on a valid/ready handshake. While the
//   word is held, no further bits are accepted.
//
//   A partial word that sits idle for TIMEOUT_CYC cycles is aborted: the
//   position mask is cleared, and timeout pulses for one cycle. Setting
//   TIMEOUT_CYC to 0 disables the abort.
//
//   With FILL_ORDER_CHECK = 1, only bits whose index matches the next
//   expected ascending index are written. Other bits are still handshaken,
//   but they are dropped and counted in err_cnt.
//
// Optional feature (macro DEMUX32_BYPASS_EN):
//   When the macro is defined, the ports bypass_word and bypass_load are
//   added. A bypass load in COLLECT writes a whole word at once and moves
//   straight to HOLD.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   bit_valid    in   1   upstream offers a bit
//   bit_ready    out  1   collector accepts the bit this cycle
//   bit_in       in   1   data bit
//   sel          in   5   destination bit index, 0..31
//   word_valid   out  1   assembled word available
//   word_ready   in   1   downstream accepts the word
//   word_out     out  32  assembled word
//   mask_out     out  32  bit i set once position i is written in this word
//   timeout      out  1   one-cycle pulse when a partial word is aborted
//   err_cnt      out  8   saturating count of dropped (out-of-order) bits
//   bypass_word  in   32  whole-word load value   (DEMUX32_BYPASS_EN only)
//   bypass_load  in   1   whole-word load strobe  (DEMUX32_BYPASS_EN only)
// ---------------------------------------------------------------------------
module demux32_collector #(
    parameter int TIMEOUT_CYC      = 255,
    parameter int FILL_ORDER_CHECK = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_valid,
    output logic        bit_ready,
    input  logic        bit_in,
    input  logic [4:0]  sel,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word_out,
    output logic [31:0] mask_out,
    output logic        timeout,
    output logic [7:0]  err_cnt
`ifdef DEMUX32_BYPASS_EN
    ,
    input  logic [31:0] bypass_word,
    input  logic        bypass_load
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYC);
    localparam bit         TIMEOUT_EN    = (TIMEOUT_CYC != 0);
    localparam bit         ORDER_EN      = (FILL_ORDER_CHECK != 0);

    state_t      state;
    state_t      next_state;

    logic [7:0]  idle_cnt;
    logic [4:0]  exp_idx;

    logic        accept;
    logic        bypass_take;
    logic        in_order;
    logic        do_write;
    logic        do_drop;
    logic        word_done;
    logic        idle_cycle;
    logic        abort;
    logic        release_word;
    logic [31:0] sel_onehot;
    logic [31:0] mask_after_write;

    // Per-cycle decode of the current event. Priority, from highest to lowest:
    //   1. bypass load
    //   2. bit accept, which is either a write or a drop
    //   3. idle timeout
    // An accept in the same cycle as the timeout threshold therefore
    // prevents the abort.
    always_comb begin
        bypass_take = 1'b0;
`ifdef DEMUX32_BYPASS_EN
        bypass_take = bypass_load && (state == COLLECT);
`endif
        accept           = bit_valid && bit_ready;
        sel_onehot       = 32'd1 << sel;
        in_order         = !ORDER_EN || (sel == exp_idx);
        do_write         = accept && in_order && !bypass_take;
        do_drop          = accept && !in_order && !bypass_take;
        mask_after_write = mask_out | sel_onehot;
        word_done        = do_write && (&mask_after_write);
        idle_cycle       = (state == COLLECT) && (mask_out != 32'd0)
                           && !accept && !bypass_take;
        abort            = TIMEOUT_EN && idle_cycle
                           && ((idle_cnt + 8'd1) == TIMEOUT_LIMIT);
        release_word     = (state == HOLD) && word_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The move to HOLD happens on the edge where the last
    // missing position is written, so word_valid rises one cycle after that
    // final bit.
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: begin
                if (bypass_take || word_done) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    next_state = COLLECT;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    // Handshake outputs depend only on the state.
    always_comb begin
        bit_ready  = (state == COLLECT);
        word_valid = (state == HOLD);
    end

    // Assembly datapath. word_out is never cleared when a word is released
    // or aborted; only mask_out tracks which positions are fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out <= 32'd0;
            mask_out <= 32'd0;
            exp_idx  <= 5'd0;
            idle_cnt <= 8'd0;
            timeout  <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            timeout <= abort;
`ifdef DEMUX32_BYPASS_EN
            if (bypass_take) begin
                word_out <= bypass_word;
                mask_out <= 32'hFFFF_FFFF;
                idle_cnt <= 8'd0;
            end else
`endif
            if (release_word) begin
                mask_out <= 32'd0;
                exp_idx  <= 5'd0;
                idle_cnt <= 8'd0;
            end else if (do_write) begin
                word_out[sel] <= bit_in;
                mask_out      <= mask_after_write;
                exp_idx       <= exp_idx + 5'd1;
                idle_cnt      <= 8'd0;
            end else if (do_drop) begin
                idle_cnt <= 8'd0;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (abort) begin
                mask_out <= 32'd0;
                exp_idx  <= 5'd0;
                idle_cnt <= 8'd0;
            end else if (idle_cycle && TIMEOUT_EN) begin
                idle_cnt <= idle_cnt + 8'd1;
            end else begin
                idle_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_demux32_collector.sv
// ---------------------------------------------------------------------------
// tb_demux32_collector
//
// Purpose:
//   Self-checking bench for demux32_collector. Three instances share the
//   same stimulus, each with different parameters:
//     instance 0: default timeout (255), no order check
//     instance 1: TIMEOUT_CYC = 4,        no order check
//     instance 2: TIMEOUT_CYC = 6,        order check enabled
//   A word-level reference model is stepped on every clock edge. Every
//   output of every instance is compared against this model once per cycle.
//   Directed scenarios also add literal expectations on top of the model.
//   Compile with DEMUX32_BYPASS_EN to include the bypass scenario.
// ---------------------------------------------------------------------------
module tb_demux32_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic [4:0]  sel = 5'd0;
    logic        word_ready = 1'b0;
`ifdef DEMUX32_BYPASS_EN
    logic [31:0] bypass_word = 32'd0;
    logic        bypass_load = 1'b0;
`endif

    logic        bit_ready  [3];
    logic        word_valid [3];
    logic        timeout    [3];
    logic [31:0] word_out   [3];
    logic [31:0] mask_out   [3];
    logic [7:0]  err_cnt    [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        demux32_collector #(
            .TIMEOUT_CYC      (g == 0 ? 255 : (g == 1 ? 4 : 6)),
            .FILL_ORDER_CHECK (g == 2 ? 1 : 0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .bit_valid  (bit_valid),
            .bit_ready  (bit_ready[g]),
            .bit_in     (bit_in),
            .sel        (sel),
            .word_valid (word_valid[g]),
            .word_ready (word_ready),
            .word_out   (word_out[g]),
            .mask_out   (mask_out[g]),
            .timeout    (timeout[g]),
            .err_cnt    (err_cnt[g])
`ifdef DEMUX32_BYPASS_EN
            ,
            .bypass_word (bypass_word),
            .bypass_load (bypass_load)
`endif
        );
    end

    // Reference model: one set of word-level variables per instance.
    logic [31:0] m_word  [3] = '{default: 32'd0};
    logic [31:0] m_mask  [3] = '{default: 32'd0};
    bit          m_hold  [3] = '{default: 1'b0};
    bit          m_tpulse[3] = '{default: 1'b0};
    int          m_exp   [3] = '{default: 0};
    int          m_idle  [3] = '{default: 0};
    int          m_err   [3] = '{default: 0};

    function automatic int toCyc(input int k);
        return (k == 0) ? 255 : ((k == 1) ? 4 : 6);
    endfunction

    function automatic bit ordChk(input int k);
        return (k == 2);
    endfunction

    task automatic modelStep(input int k);
        m_tpulse[k] = 1'b0;
        if (m_hold[k]) begin
            if (word_ready) begin
                m_hold[k] = 1'b0;
                m_mask[k] = 32'd0;
                m_exp[k]  = 0;
            end
            m_idle[k] = 0;
        end
`ifdef DEMUX32_BYPASS_EN
        else if (bypass_load) begin
            m_word[k] = bypass_word;
            m_mask[k] = 32'hFFFF_FFFF;
            m_hold[k] = 1'b1;
            m_idle[k] = 0;
        end
`endif
        else if (bit_valid) begin
            m_idle[k] = 0;
            if (!ordChk(k) || (int'(sel) == m_exp[k])) begin
                m_word[k][sel] = bit_in;
                m_mask[k][sel] = 1'b1;
                m_exp[k] = (m_exp[k] + 1) % 32;
                if (m_mask[k] == 32'hFFFF_FFFF) m_hold[k] = 1'b1;
            end else if (m_err[k] < 255) begin
                m_err[k] = m_err[k] + 1;
            end
        end else if (m_mask[k] != 32'd0 && toCyc(k) != 0) begin
            m_idle[k] = m_idle[k] + 1;
            if (m_idle[k] == toCyc(k)) begin
                m_mask[k]   = 32'd0;
                m_exp[k]    = 0;
                m_idle[k]   = 0;
                m_tpulse[k] = 1'b1;
            end
        end else begin
            m_idle[k] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_word[k] = 32'd0;  m_mask[k] = 32'd0;
                m_hold[k] = 1'b0;   m_tpulse[k] = 1'b0;
                m_exp[k]  = 0;      m_idle[k] = 0;  m_err[k] = 0;
            end else begin
                modelStep(k);
            end
        end
    end

    task automatic checkOutput(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s[%0d] at %0t: got %h, expected %h",
                     name, k, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    task automatic compareAll();
        for (int k = 0; k < 3; k++) begin
            checkOutput("word_valid", k, 32'(word_valid[k]), 32'(m_hold[k]));
            checkOutput("bit_ready",  k, 32'(bit_ready[k]),  32'(!m_hold[k]));
            checkOutput("word_out",   k, word_out[k],        m_word[k]);
            checkOutput("mask_out",   k, mask_out[k],        m_mask[k]);
            checkOutput("timeout",    k, 32'(timeout[k]),    32'(m_tpulse[k]));
            checkOutput("err_cnt",    k, 32'(err_cnt[k]),    32'(m_err[k]));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic b,
                                 input logic [4:0] s, input logic r);
        @(negedge clk);
        compareAll();
        bit_valid  = v;
        bit_in     = b;
        sel        = s;
        word_ready = r;
    endtask

    task automatic checkResetValues(input string tag);
        for (int k = 0; k < 3; k++) begin
            checkOutput({tag, "_word_out"},   k, word_out[k],          32'd0);
            checkOutput({tag, "_mask_out"},   k, mask_out[k],          32'd0);
            checkOutput({tag, "_word_valid"}, k, 32'(word_valid[k]),   32'd0);
            checkOutput({tag, "_bit_ready"},  k, 32'(bit_ready[k]),    32'd1);
            checkOutput({tag, "_timeout"},    k, 32'(timeout[k]),      32'd0);
            checkOutput({tag, "_err_cnt"},    k, 32'(err_cnt[k]),      32'd0);
        end
    endtask

    // Reset is asserted between clock edges, and the outputs are checked
    // before any clock edge arrives. This verifies that the reset is
    // asynchronous.
    task automatic resetDut();
        @(negedge clk);
        compareAll();
        #2;
        rst_n = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; sel = 5'd0; word_ready = 1'b0;
`ifdef DEMUX32_BYPASS_EN
        bypass_load = 1'b0;
`endif
        #1;
        checkResetValues("reset");
        @(negedge clk);
        compareAll();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] src;
        int          seq[$];
        int          idle_left;
        logic        v;
        logic [4:0]  s;

        repeat (2) @(negedge clk);
        resetDut();

        // Scenario 1: ascending fill with downstream always ready.
        src = 32'hEE0E5EA0;
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, src[i], 5'(i), 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t1_valid", k, 32'(word_valid[k]), 32'd1);
            checkOutput("t1_word",  k, word_out[k],        32'hEE0E5EA0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t1_reenter_valid", 0, 32'(word_valid[0]), 32'd0);
        checkOutput("t1_reenter_mask",  0, mask_out[0],        32'd0);

        // Scenario 2: descending fill, then held for 10 cycles while extra
        // bits are offered.
        resetDut();
        src = 32'h0AB000B0;
        for (int i = 31; i >= 0; i--) applyStimulus(1'b1, src[i], 5'(i), 1'b0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'($urandom), 5'($urandom), 1'b0);
            checkOutput("t2_hold_valid", 0, 32'(word_valid[0]), 32'd1);
            checkOutput("t2_hold_ready", 0, 32'(bit_ready[0]),  32'd0);
            checkOutput("t2_hold_word",  0, word_out[0],        32'h0AB000B0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t2_released", 0, 32'(word_valid[0]), 32'd0);

        // Scenario 3: partial word of 6 bits, then idle, which triggers the
        // timeout on instance 1. A full word follows afterwards.
        resetDut();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'($urandom), 5'(i), 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t3_timeout_pulse", 1, 32'(timeout[1]), 32'd1);
        checkOutput("t3_timeout_mask",  1, mask_out[1],     32'd0);
        checkOutput("t3_no_timeout",    0, 32'(timeout[0]), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        checkOutput("t3_pulse_end", 1, 32'(timeout[1]), 32'd0);
        src = 32'h100200E5;
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, src[i], 5'(i), 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("t3_valid", 1, 32'(word_valid[1]), 32'd1);
        checkOutput("t3_word",  1, word_out[1],        32'h100200E5);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);

        // Scenario 4: the index-3 bit is offered out of order, with an
        // inverted value.
        resetDut();
        src = 32'h5EA00E5E;
        seq = {0, 1, 3, 2};
        for (int i = 3; i < 32; i++) seq.push_back(i);
        foreach (seq[j]) begin
            if (j == 2) applyStimulus(1'b1, ~src[seq[j]], 5'(seq[j]), 1'b0);
            else        applyStimulus(1'b1,  src[seq[j]], 5'(seq[j]), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
        checkOutput("t4_valid",   2, 32'(word_valid[2]), 32'd1);
        checkOutput("t4_word",    2, word_out[2],        32'h5EA00E5E);
        checkOutput("t4_err",     2, 32'(err_cnt[2]),    32'd1);
        checkOutput("t4_word_nc", 0, word_out[0],        32'h5EA00E5E);
        checkOutput("t4_err_nc",  0, 32'(err_cnt[0]),    32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);

        // Scenario 5: reset after 20 bits, then a fresh word.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'($urandom), 5'(i), 1'b0);
        resetDut();
        src = 32'hD0D020E0;
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, src[i], 5'(i), 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t5_valid", k, 32'(word_valid[k]), 32'd1);
            checkOutput("t5_word",  k, word_out[k],        32'hD0D020E0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);

`ifdef DEMUX32_BYPASS_EN
        // Bypass scenario: a whole-word load part way into a partial word.
        // It arrives together with a bit offer, which must be ignored.
        resetDut();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 5'(i), 1'b0);
        @(negedge clk);
        compareAll();
        bypass_word = 32'h0607A061;
        bypass_load = 1'b1;
        bit_valid = 1'b1; bit_in = 1'b1; sel = 5'd4;
        @(negedge clk);
        compareAll();
        bypass_load = 1'b0;
        bit_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("byp_valid", k, 32'(word_valid[k]), 32'd1);
            checkOutput("byp_word",  k, word_out[k],        32'h0607A061);
            checkOutput("byp_mask",  k, mask_out[k],        32'hFFFFFFFF);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
`endif

        // Randomized phase. It includes idle bursts (to reach the timeouts),
        // a mix of in-order and random indices for the order checker, random
        // backpressure, and occasional resets.
        resetDut();
        idle_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (idle_left > 0) begin
                v = 1'b0;
                idle_left--;
            end else if ($urandom_range(99) < 2) begin
                v = 1'b0;
                idle_left = int'($urandom_range(8, 3));
            end else begin
                v = ($urandom_range(99) < 85);
            end
            s = $urandom_range(1) ? 5'(m_exp[2]) : 5'($urandom_range(31));
            if ($urandom_range(999) < 2) resetDut();
            else applyStimulus(v, 1'($urandom_range(1)), s, ($urandom_range(99) < 40));
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
